// File: rtl/sram_bus_bridge.sv
// Valid/ready word-request bridge to a single-port SRAM macro with 1-cycle read latency.
// Byte-enable writes are done as read-modify-write; out-of-range accesses return an error.
module sram_bus_bridge #(
    parameter int unsigned DEPTH = 816,
    parameter int unsigned AW    = 10
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [3:0]    req_be,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          sram_ceb,
    output logic          sram_web,
    output logic [AW-1:0] sram_a,
    output logic [31:0]   sram_d,
    input  logic [31:0]   sram_q
);

    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDQ,
        S_WR,
        S_RMW_RD,
        S_RMW_WR
    } state_t;

    state_t state, state_nx;

    logic          cap_we;
    logic [AW-1:0] cap_idx;
    logic [DW-1:0] cap_wdata;
    logic [BW-1:0] cap_be;

    logic          accept;
    logic          in_range;
    logic          cap_load;
    logic          rsp_load;
    logic          rsp_err_nx;
    logic [DW-1:0] rsp_rdata_nx;
    logic [DW-1:0] byte_mask;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    assign req_ready = (state == S_IDLE) & RST_N;
    assign accept    = req_valid & req_ready;
    assign in_range  = req_addr[31:2] < 30'(DEPTH);
    assign sram_a    = cap_idx;

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < int'(BW); i++) begin
            byte_mask[8*i +: 8] = {8{cap_be[i]}};
        end
    end

    // Next state, response load and SRAM strobes; strobes are gated by RST_N.
    always_comb begin
        state_nx     = state;
        cap_load     = 1'b0;
        rsp_load     = 1'b0;
        rsp_err_nx   = 1'b0;
        rsp_rdata_nx = '0;
        sram_ceb     = 1'b1;
        sram_web     = 1'b1;
        sram_d       = cap_wdata;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    cap_load = 1'b1;
                    if (!in_range) begin
                        rsp_load   = 1'b1;
                        rsp_err_nx = 1'b1;
                    end else if (!req_we) begin
                        state_nx = S_RD;
                    end else if (req_be == 4'h0) begin
                        rsp_load = 1'b1;
                    end else if (req_be == 4'hF) begin
                        state_nx = S_WR;
                    end else begin
                        state_nx = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                sram_ceb = ~RST_N;
                state_nx = S_RDQ;
            end
            S_RDQ: begin
                rsp_load     = 1'b1;
                rsp_rdata_nx = sram_q;
                state_nx     = S_IDLE;
            end
            S_WR: begin
                sram_ceb = ~RST_N;
                sram_web = ~RST_N;
                rsp_load = 1'b1;
                state_nx = S_IDLE;
            end
            S_RMW_RD: begin
                sram_ceb = ~RST_N;
                state_nx = S_RMW_WR;
            end
            S_RMW_WR: begin
                sram_ceb = ~RST_N;
                sram_web = ~RST_N;
                sram_d   = (sram_q & ~byte_mask) | (cap_wdata & byte_mask);
                rsp_load = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State, captured request and registered response.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            cap_we    <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nx;
            rsp_valid <= rsp_load;
            if (rsp_load) begin
                rsp_err   <= rsp_err_nx;
                rsp_rdata <= rsp_rdata_nx;
            end
            if (cap_load) begin
                cap_we    <= req_we;
                cap_idx   <= req_addr[AW+1:2];
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
            end
        end
    end

    logic unused_cap_we;
    assign unused_cap_we = cap_we;

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Self-checking bench for sram_bus_bridge: SRAM macro model, word-level reference model,
// directed table, hand-written multi-cycle sequences and randomized requests.
module tb_sram_bus_bridge;

    localparam int unsigned DEPTH = 816;
    localparam int unsigned AW    = 10;
    localparam int unsigned MSIZE = 1 << AW;

    logic          CLK;
    logic          RST_N;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_be;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          sram_ceb;
    logic          sram_web;
    logic [AW-1:0] sram_a;
    logic [31:0]   sram_d;
    logic [31:0]   sram_q;

    sram_bus_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM macro model: full address space so aliased writes become visible.
    logic [31:0] sram_mem [MSIZE];
    always @(posedge CLK) begin
        if (!sram_web) sram_mem[sram_a] <= sram_d;
        if (!sram_ceb) sram_q <= sram_mem[sram_a];
    end

    // Reference model: word array and response rules.
    logic [31:0] ref_mem [DEPTH];
    int n_pass = 0;
    int n_total = 0;

    function automatic logic [31:0] init_val(int i);
        return {16'hA5A5, 16'(i)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rd, output logic er,
                         output int lat);
        int unsigned idx;
        idx = int'(addr >> 2);
        rd = 32'h0; er = 1'b0;
        if (idx >= DEPTH) begin
            er = 1'b1; lat = 1;
        end else if (!we) begin
            rd = ref_mem[idx]; lat = 3;
        end else if (be == 4'h0) begin
            lat = 1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            lat = (be == 4'hF) ? 2 : 3;
        end
    endtask

    // One request from a negedge: wait for ready, transfer, measure response latency.
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] e_rd;
        logic e_er;
        int e_lat, lat, n;
        model(we, addr, wdata, be, e_rd, e_er, e_lat);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge CLK); n++; end
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        req_wdata = 32'hBAD0BAD0;
        req_addr  = 32'h0000_0040;
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(negedge CLK); lat++; end
        chk({name, "_lat"}, 32'(lat), 32'(e_lat));
        chk({name, "_rdata"}, rsp_rdata, e_rd);
        chk({name, "_err"}, 32'(rsp_err), 32'(e_er));
        @(negedge CLK);
        chk({name, "_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] e_rd, got [4];
        logic        e_er;
        int          e_lat, lat, k, nr;
        int          acc_cyc [4];
        logic        acc;
        int          bad;

        vecs[0]  = '{"rd_last",     1'b0, 32'h0000_0CBC, 32'h0,          4'hF, 32'hA5A5_032F, 1'b0, 3};
        vecs[1]  = '{"rd_816",      1'b0, 32'h0000_0CC0, 32'h0,          4'hF, 32'h0,         1'b1, 1};
        vecs[2]  = '{"wr_1000",     1'b1, 32'h0000_1000, 32'h1234_5678,  4'hF, 32'h0,         1'b1, 1};
        vecs[3]  = '{"wr_be0",      1'b1, 32'h0000_0020, 32'hFFFF_FFFF,  4'h0, 32'h0,         1'b0, 1};
        vecs[4]  = '{"rd_be0_chk",  1'b0, 32'h0000_0020, 32'h0,          4'h0, 32'hA5A5_0008, 1'b0, 3};
        vecs[5]  = '{"wr_last",     1'b1, 32'h0000_0CBC, 32'h1122_3344,  4'hF, 32'h0,         1'b0, 2};
        vecs[6]  = '{"rd_last2",    1'b0, 32'h0000_0CBC, 32'h0,          4'h0, 32'h1122_3344, 1'b0, 3};
        vecs[7]  = '{"rmw_9",       1'b1, 32'h0000_0024, 32'hCCDD_EEFF,  4'h9, 32'h0,         1'b0, 3};
        vecs[8]  = '{"rd_9",        1'b0, 32'h0000_0024, 32'h0,          4'h0, 32'hCCA5_00FF, 1'b0, 3};
        vecs[9]  = '{"rmw_lsb",     1'b1, 32'h0000_002B, 32'h0000_BEEF,  4'h3, 32'h0,         1'b0, 3};
        vecs[10] = '{"rd_10",       1'b0, 32'h0000_0028, 32'h0,          4'h0, 32'hA5A5_BEEF, 1'b0, 3};
        vecs[11] = '{"rd_top",      1'b0, 32'hFFFF_FFFC, 32'h0,          4'hF, 32'h0,         1'b1, 1};

        for (int i = 0; i < int'(MSIZE); i++) sram_mem[i] = init_val(i);
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_val(i);
        sram_q = '0;

        // Reset held with a full write pending on the bus.
        RST_N = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
        req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("rst_web",   32'(sram_web),  32'd1);
            chk("rst_ceb",   32'(sram_ceb),  32'd1);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_rspv",  32'(rsp_valid), 32'd0);
        end
        RST_N = 1'b1;
        #1 chk("rel_ready", 32'(req_ready), 32'd1);

        // First accept right after release is the full write of 0x10.
        model(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, e_rd, e_er, e_lat);
        @(negedge CLK);
        req_valid = 1'b0;
        chk("wr_t1_web", 32'(sram_web), 32'd0);
        chk("wr_t1_ceb", 32'(sram_ceb), 32'd0);
        chk("wr_t1_a",   32'(sram_a),   32'd4);
        chk("wr_t1_d",   sram_d,        32'hDEAD_BEEF);
        chk("wr_t1_rspv", 32'(rsp_valid), 32'd0);
        @(negedge CLK);
        chk("wr_t2_rspv", 32'(rsp_valid), 32'd1);
        chk("wr_t2_err",  32'(rsp_err),   32'd0);
        chk("wr_t2_rd",   rsp_rdata,      32'h0);
        @(negedge CLK);
        chk("wr_t3_rspv", 32'(rsp_valid), 32'd0);

        do_req("rd_10", 1'b0, 32'h10, 32'h0, 4'hF);

        // Partial write: read strobe in T1, merged write in T2, response in T3.
        model(1'b1, 32'h10, 32'h0000_5A00, 4'b0010, e_rd, e_er, e_lat);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0000_5A00; req_be = 4'b0010;
        @(negedge CLK);
        req_valid = 1'b0; req_wdata = 32'h0; req_be = 4'hF;
        chk("rmw_t1_ceb", 32'(sram_ceb), 32'd0);
        chk("rmw_t1_web", 32'(sram_web), 32'd1);
        chk("rmw_t1_a",   32'(sram_a),   32'd4);
        @(negedge CLK);
        chk("rmw_t2_web", 32'(sram_web), 32'd0);
        chk("rmw_t2_d",   sram_d,        32'hDEAD_5AEF);
        chk("rmw_t2_rspv", 32'(rsp_valid), 32'd0);
        @(negedge CLK);
        chk("rmw_t3_rspv", 32'(rsp_valid), 32'd1);
        @(negedge CLK);
        do_req("rmw_rb", 1'b0, 32'h10, 32'h0, 4'h0);
        chk("rmw_ref", ref_mem[4], 32'hDEAD_5AEF);

        // Directed table.
        foreach (vecs[i]) begin
            model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, e_rd, e_er, e_lat);
            for (int u = 0; u < int'(DEPTH); u++) if (u == 0) ; // keep ref in sync only via model
            req_valid = 1'b1; req_we = vecs[i].we; req_addr = vecs[i].addr;
            req_wdata = vecs[i].wdata; req_be = vecs[i].be;
            @(negedge CLK);
            req_valid = 1'b0;
            chk({vecs[i].name, "_t1_web"}, 32'(sram_web), vecs[i].exp_err ? 32'd1 : 32'(sram_web));
            lat = 1;
            while (!rsp_valid && lat < 10) begin @(negedge CLK); lat++; end
            chk({vecs[i].name, "_lat"},   32'(lat),       32'(vecs[i].exp_lat));
            chk({vecs[i].name, "_rdata"}, rsp_rdata,      vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"},   32'(rsp_err),   32'(vecs[i].exp_err));
            @(negedge CLK);
        end

        // Back-to-back reads with req_valid held.
        k = 0; nr = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_be = 4'h0;
        for (int c = 0; c < 20; c++) begin
            acc = req_valid & req_ready;
            if (rsp_valid && nr < 4) begin got[nr] = rsp_rdata; nr++; end
            @(negedge CLK);
            if (acc && k < 4) begin
                acc_cyc[k] = c; k++;
                if (k == 4) req_valid = 1'b0;
                else req_addr = 32'(4 * k);
            end
        end
        chk("b2b_accepts", 32'(k), 32'd4);
        chk("b2b_rsps",    32'(nr), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk("b2b_cycle", 32'(acc_cyc[j]), 32'(3 * j));
            chk("b2b_data",  got[j], ref_mem[j]);
        end

        // be==0 write then a read accepted in the response cycle.
        model(1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, e_rd, e_er, e_lat);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hFFFF_FFFF; req_be = 4'h0;
        @(negedge CLK);
        req_we = 1'b0; req_addr = 32'h8;
        chk("be0_rspv",  32'(rsp_valid), 32'd1);
        chk("be0_ready", 32'(req_ready), 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        chk("be0_rd_t1_ceb", 32'(sram_ceb), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        chk("be0_rd_rspv", 32'(rsp_valid), 32'd1);
        chk("be0_rd_data", rsp_rdata, ref_mem[2]);
        @(negedge CLK);

        // Reset asserted during the RMW write cycle.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h00FF_0000; req_be = 4'b0100;
        @(negedge CLK);
        req_valid = 1'b0;
        @(posedge CLK);
        #1 RST_N = 1'b0;
        @(negedge CLK);
        chk("mid_rst_web",  32'(sram_web),  32'd1);
        chk("mid_rst_rspv", 32'(rsp_valid), 32'd0);
        @(negedge CLK);
        chk("mid_rst_rspv2", 32'(rsp_valid), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("mid_rst_rspv3", 32'(rsp_valid), 32'd0);
        do_req("mid_rst_rb", 1'b0, 32'h30, 32'h0, 4'h0);

        // Randomized requests against the reference model.
        for (int r = 0; r < 60; r++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 900)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) a = $urandom;
            do_req("rand", 1'($urandom), a, $urandom, 4'($urandom));
        end

        // Whole-memory comparison, including the region past DEPTH.
        repeat (2) @(negedge CLK);
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (sram_mem[i] !== ref_mem[i]) bad++;
        chk("mem_contents", 32'(bad), 32'd0);
        bad = 0;
        for (int i = int'(DEPTH); i < int'(MSIZE); i++) if (sram_mem[i] !== init_val(i)) bad++;
        chk("mem_no_alias", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sram_bus_bridge.md
Name: sram_bus_bridge

Overview:
- Bus-to-SRAM controller sitting directly upstream of the 32-bit x 816-word single-port SRAM macro (ports CLK/CEB/WEB/A/D/Q, 1-cycle registered read, write whenever WEB low).
- Accepts valid/ready word requests from the CPU load/store or fetch path and generates legal SRAM strobes.
- Absorbs the 1-cycle read latency, implements byte-enable writes via read-modify-write (the macro has no byte mask), range-checks addresses and returns a registered response.

Parameters:
- DEPTH, 816, number of 32-bit words in the attached SRAM; legal word indices 0..DEPTH-1.
- AW, 10, SRAM word-address width; must satisfy 2^AW >= DEPTH.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept; transfer occurs when req_valid & req_ready at a rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; bits [1:0] ignored; word index = req_addr[31:2].
- req_wdata  in  32  write data (byte lane i = bits 8i+7:8i).
- req_be  in  4  byte enables, writes only.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  32  read data; 0 for writes and errors; holds until next response.
- rsp_err  out  1  out-of-range access; valid with rsp_valid.
- sram_ceb  out  1  to SRAM CEB, active-low.
- sram_web  out  1  to SRAM WEB, active-low.
- sram_a  out  AW  to SRAM A.
- sram_d  out  32  to SRAM D.
- sram_q  in  32  from SRAM Q.

Behaviour:
- Reset (RST_N=0 at edge): state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, captured request regs cleared. req_ready=0 and sram_web=1, sram_ceb=1 combinationally while RST_N=0 (web gated by RST_N so no write strobe can escape).
- Idle SRAM levels: ceb=1, web=1, sram_a/sram_d = captured regs (don't-care). web=0 only in WR and RMW_WR; the macro writes on ~WEB regardless of CEB.
- req_ready = (state==IDLE) & RST_N. Accept captures we, word index, wdata, be.
- Range: err if req_addr[31:2] >= DEPTH. No SRAM access. Response in next cycle (T1): rsp_err=1, rdata=0. Write with be==0 likewise: no access, rsp in T1, err=0. State stays IDLE, so a new request may be accepted in T1.
- Read (accept at T0):
  - RD (T1): ceb=0, web=1, a=idx.
  - RDQ (T2): sram_q valid; rsp_rdata<=sram_q, rsp_valid<=1.
  - IDLE (T3): rsp_valid=1, req_ready=1.
  - Latency 3; throughput one read per 3 cycles.
- Full write (be==4'hF):
  - WR (T1): ceb=0, web=0, a=idx, d=wdata.
  - IDLE (T2): rsp_valid=1, err=0, rdata=0.
- Partial write (be not 0, not F):
  - RMW_RD (T1): read strobe as RD.
  - RMW_WR (T2): ceb=0, web=0, d = (sram_q & ~M) | (wdata & M), M = byte mask expanded from be (combinational from sram_q).
  - IDLE (T3): response.
- rsp_valid high exactly one cycle per accepted request; never two in a row from one request.
- Reset mid-operation: transaction abandoned, no response, no SRAM write in any cycle where RST_N=0; memory retains prior contents.
- req_* changes while not ready: ignored; captured values used for whole transaction.

Test Plan:
- Reset: RST_N=0 for 5 cycles with req_valid=1, req_we=1, be=F -> sram_web=1, sram_ceb=1, req_ready=0, rsp_valid=0 every cycle; first accept on cycle after release.
- Full write then read: write addr 0x10, data 0xDEADBEEF, be=F -> T1 web=0, a=4, d=0xDEADBEEF; rsp at T2. Read 0x10 -> rsp at T3, rdata=0xDEADBEEF, err=0.
- RMW: after above, write 0x10, wdata 0x00005A00, be=4'b0010 -> T1 read strobe, T2 write d=0xDEAD5AEF; rsp T3. Readback -> 0xDEAD5AEF.
- Range: read 0xCBC (word 815) -> normal access. Read 0xCC0 (word 816) and write 0x1000 -> rsp in T1, err=1, rdata=0, ceb/web stay 1. Word 816 is not written via aliasing.
- Back-to-back: req_valid held with four reads of 0x0,0x4,0x8,0xC -> accepts every 3 cycles, four rsp pulses with correct data in order. be==0 write -> rsp in T1 and next accept in T1.
- Reset mid-RMW: assert RST_N=0 during RMW_WR cycle -> web=1 that cycle, no rsp_valid. Readback after release returns the unmodified word.
